// File: rtl/axis2bram_writer.sv
// AXI4-Stream to ping-pong BRAM writer: splits each beat into BRAM words, fills one bank per frame.
// Optional TLAST handling (early frame end, overrun drain, sticky error) is enabled by AXIS2BRAM_TLAST_CHECK_EN.
module axis2bram_writer #(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_BRAM_DATA_WIDTH = 32,
    parameter int C_BRAM_ADDR_WIDTH = 10,
    parameter int C_BRAM_DATA_DEPTH = 1024
) (
    input  logic                             ACC_CLK,
    input  logic                             ARESETN,
    input  logic [C_AXIS_DATA_WIDTH-1:0]     AXIS_TDATA,
    input  logic                             AXIS_TVALID,
    input  logic                             AXIS_TLAST,
    output logic                             AXIS_TREADY,
    input  logic [31:0]                      DATA_DEPTH,
    input  logic                             DATA_DEPTH_EMPTY,
    output logic                             DATA_DEPTH_READ,
    output logic [C_BRAM_ADDR_WIDTH-1:0]     BRAM_ADDR,
    output logic [C_BRAM_DATA_WIDTH-1:0]     BRAM_DOUT,
    output logic [C_BRAM_DATA_WIDTH/8-1:0]   BRAM_WE,
    output logic                             BRAM_EN,
    output logic                             BRAM_BANK,
    output logic                             CTRL_CANSTART,
    output logic                             CTRL_ACC_BANK,
    input  logic                             CTRL_ACC_DONE,
    output logic [C_BRAM_ADDR_WIDTH:0]       STAT_WORDS,
    output logic                             STAT_TLAST_ERR
);
    localparam int N  = C_AXIS_DATA_WIDTH / C_BRAM_DATA_WIDTH;
    localparam int CW = C_BRAM_ADDR_WIDTH + 1;
    localparam logic [1:0] LAST_LANE = 2'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RECV  = 3'd2,
        S_SPLIT = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                          state_reg, state_next, end_state;
    logic [CW-1:0]                   depth_reg, count_reg, depth_clamped;
    logic [C_AXIS_DATA_WIDTH-1:0]    beat_reg;
    logic [1:0]                      lane_reg;
    logic [1:0]                      full_reg, full_next;
    logic                            wr_bank_reg, acc_bank_reg, acc_bank_next, canstart_reg;
    logic [C_BRAM_ADDR_WIDTH-1:0]    bram_addr_reg;
    logic [C_BRAM_DATA_WIDTH-1:0]    bram_dout_reg, wr_data;
    logic [C_BRAM_DATA_WIDTH/8-1:0]  bram_we_reg;
    logic                            bram_en_reg, bram_bank_reg;
    logic [CW-1:0]                   stat_words_reg;
    logic                            tready_int, depth_read_int, handshake;
    logic                            wr_fire, lane_final, depth_hit, frame_end, done_take;
    logic [C_BRAM_DATA_WIDTH-1:0]    lane_words [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < N) begin : g_used
                assign lane_words[gi] = beat_reg[gi*C_BRAM_DATA_WIDTH +: C_BRAM_DATA_WIDTH];
            end else begin : g_pad
                assign lane_words[gi] = '0;
            end
        end
    endgenerate

    assign handshake     = AXIS_TVALID && tready_int;
    assign wr_fire       = (state_reg == S_RECV && handshake) || (state_reg == S_SPLIT);
    assign wr_data       = (state_reg == S_SPLIT) ? lane_words[lane_reg]
                                                  : AXIS_TDATA[C_BRAM_DATA_WIDTH-1:0];
    assign lane_final    = (state_reg == S_SPLIT) ? (lane_reg == LAST_LANE) : (N == 1);
    assign depth_hit     = wr_fire && (count_reg + CW'(1) == depth_reg);
    assign done_take     = CTRL_ACC_DONE && full_reg[acc_bank_reg];
    assign acc_bank_next = acc_bank_reg ^ done_take;
    assign depth_clamped = (DATA_DEPTH == 32'd0 || DATA_DEPTH > 32'(C_BRAM_DATA_DEPTH))
                         ? CW'(C_BRAM_DATA_DEPTH) : DATA_DEPTH[CW-1:0];

`ifdef AXIS2BRAM_TLAST_CHECK_EN
    logic last_reg, beat_last, overrun, tlast_err_reg;
    assign beat_last      = (state_reg == S_SPLIT) ? last_reg : AXIS_TLAST;
    assign frame_end      = depth_hit || (wr_fire && beat_last && lane_final);
    // Depth exhausted on a beat without TLAST: rest of the frame must be swallowed.
    assign overrun        = depth_hit && !beat_last;
    assign end_state      = overrun ? S_DRAIN : S_IDLE;
    assign STAT_TLAST_ERR = tlast_err_reg;

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_reg      <= 1'b0;
            tlast_err_reg <= 1'b0;
        end else begin
            if (state_reg == S_RECV && handshake)
                last_reg <= AXIS_TLAST;
            if (overrun)
                tlast_err_reg <= 1'b1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast   = AXIS_TLAST ^ lane_final;
    assign frame_end      = depth_hit;
    assign end_state      = S_IDLE;
    assign STAT_TLAST_ERR = 1'b0;
`endif

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!DATA_DEPTH_EMPTY && !full_reg[wr_bank_reg]) state_next = S_LOAD;
            S_LOAD:  state_next = S_RECV;
            S_RECV: begin
                if (handshake) begin
                    if (frame_end)  state_next = end_state;
                    else if (N > 1) state_next = S_SPLIT;
                end
            end
            S_SPLIT: begin
                if (frame_end)                   state_next = end_state;
                else if (lane_reg == LAST_LANE)  state_next = S_RECV;
            end
`ifdef AXIS2BRAM_TLAST_CHECK_EN
            S_DRAIN: if (handshake && AXIS_TLAST) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tready_int     = 1'b0;
        depth_read_int = 1'b0;
        case (state_reg)
            S_LOAD:  depth_read_int = 1'b1;
            S_RECV:  tready_int     = 1'b1;
`ifdef AXIS2BRAM_TLAST_CHECK_EN
            S_DRAIN: tready_int     = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        full_next = full_reg;
        if (frame_end) full_next[wr_bank_reg]  = 1'b1;
        if (done_take) full_next[acc_bank_reg] = 1'b0;
    end

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            depth_reg      <= '0;
            count_reg      <= '0;
            beat_reg       <= '0;
            lane_reg       <= '0;
            full_reg       <= '0;
            wr_bank_reg    <= 1'b0;
            acc_bank_reg   <= 1'b0;
            canstart_reg   <= 1'b0;
            bram_addr_reg  <= '0;
            bram_dout_reg  <= '0;
            bram_we_reg    <= '0;
            bram_en_reg    <= 1'b0;
            bram_bank_reg  <= 1'b0;
            stat_words_reg <= '0;
        end else begin
            bram_en_reg <= 1'b0;
            bram_we_reg <= '0;
            if (state_reg == S_LOAD) begin
                depth_reg <= depth_clamped;
                count_reg <= '0;
            end
            if (state_reg == S_RECV && handshake) begin
                beat_reg <= AXIS_TDATA;
                lane_reg <= 2'd1;
            end else if (state_reg == S_SPLIT) begin
                lane_reg <= lane_reg + 2'd1;
            end
            if (wr_fire) begin
                bram_en_reg   <= 1'b1;
                bram_we_reg   <= '1;
                bram_addr_reg <= count_reg[C_BRAM_ADDR_WIDTH-1:0];
                bram_dout_reg <= wr_data;
                bram_bank_reg <= wr_bank_reg;
                count_reg     <= count_reg + CW'(1);
            end
            if (frame_end) begin
                wr_bank_reg    <= ~wr_bank_reg;
                stat_words_reg <= count_reg + CW'(1);
            end
            full_reg     <= full_next;
            acc_bank_reg <= acc_bank_next;
            // Sample the pre-update full flag so CANSTART trails the bank's final write by a cycle.
            canstart_reg <= full_reg[acc_bank_next];
        end
    end

    assign AXIS_TREADY     = tready_int;
    assign DATA_DEPTH_READ = depth_read_int;
    assign BRAM_ADDR       = bram_addr_reg;
    assign BRAM_DOUT       = bram_dout_reg;
    assign BRAM_WE         = bram_we_reg;
    assign BRAM_EN         = bram_en_reg;
    assign BRAM_BANK       = bram_bank_reg;
    assign CTRL_CANSTART   = canstart_reg;
    assign CTRL_ACC_BANK   = acc_bank_reg;
    assign STAT_WORDS      = stat_words_reg;

endmodule

// File: tb/tb_axis2bram_writer.sv
// Directed bench for axis2bram_writer: N=2 instance for framing/banking, N=1 instance for the depth-0 clamp.
// Expectations follow AXIS2BRAM_TLAST_CHECK_EN when it is defined for the build.
module tb_axis2bram_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] tdata;
    logic        tvalid, tlast, tready;
    logic [31:0] depth;
    logic        depth_empty, depth_read;
    logic [9:0]  bram_addr;
    logic [31:0] bram_dout;
    logic [3:0]  bram_we;
    logic        bram_en, bram_bank, canstart, acc_bank, acc_done, stat_err;
    logic [10:0] stat_words;

    logic [31:0] b_tdata;
    logic        b_tvalid, b_tready, b_empty, b_depth_read;
    logic        b_tlast = 1'b0;
    logic        b_acc_done = 1'b0;
    logic [31:0] b_depth = 32'd0;
    logic [9:0]  b_addr;
    logic [31:0] b_dout;
    logic [3:0]  b_we;
    logic        b_en, b_bank, b_canstart, b_acc_bank, b_stat_err;
    logic [10:0] b_stat_words;

    axis2bram_writer dut (
        .ACC_CLK(clk), .ARESETN(rst_n),
        .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(tready),
        .DATA_DEPTH(depth), .DATA_DEPTH_EMPTY(depth_empty), .DATA_DEPTH_READ(depth_read),
        .BRAM_ADDR(bram_addr), .BRAM_DOUT(bram_dout), .BRAM_WE(bram_we), .BRAM_EN(bram_en),
        .BRAM_BANK(bram_bank), .CTRL_CANSTART(canstart), .CTRL_ACC_BANK(acc_bank),
        .CTRL_ACC_DONE(acc_done), .STAT_WORDS(stat_words), .STAT_TLAST_ERR(stat_err)
    );

    axis2bram_writer #(.C_AXIS_DATA_WIDTH(32)) dut_n1 (
        .ACC_CLK(clk), .ARESETN(rst_n),
        .AXIS_TDATA(b_tdata), .AXIS_TVALID(b_tvalid), .AXIS_TLAST(b_tlast), .AXIS_TREADY(b_tready),
        .DATA_DEPTH(b_depth), .DATA_DEPTH_EMPTY(b_empty), .DATA_DEPTH_READ(b_depth_read),
        .BRAM_ADDR(b_addr), .BRAM_DOUT(b_dout), .BRAM_WE(b_we), .BRAM_EN(b_en),
        .BRAM_BANK(b_bank), .CTRL_CANSTART(b_canstart), .CTRL_ACC_BANK(b_acc_bank),
        .CTRL_ACC_DONE(b_acc_done), .STAT_WORDS(b_stat_words), .STAT_TLAST_ERR(b_stat_err)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    logic        pop_pending = 1'b0;
    logic        canstart_prev = 1'b0;
    logic [31:0] dq[$];
    logic [42:0] wr_log[$];
    int          b_wr_count = 0;
    logic [9:0]  b_last_addr = '0;
    logic [31:0] b_last_data = '0;
    logic        b_hs_pending = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic bank,
                            input logic [9:0] addr, input logic [31:0] data);
        logic [42:0] e;
        e = (idx < wr_log.size()) ? wr_log[idx] : '1;
        check_eq(tag, e, {bank, addr, data});
    endtask

    task automatic check_zero_outputs(input string p);
        check_eq({p, "_tready"}, tready, 0);
        check_eq({p, "_depth_read"}, depth_read, 0);
        check_eq({p, "_en"}, bram_en, 0);
        check_eq({p, "_we"}, bram_we, 0);
        check_eq({p, "_addr"}, bram_addr, 0);
        check_eq({p, "_dout"}, bram_dout, 0);
        check_eq({p, "_bank"}, bram_bank, 0);
        check_eq({p, "_canstart"}, canstart, 0);
        check_eq({p, "_acc_bank"}, acc_bank, 0);
        check_eq({p, "_stat_words"}, stat_words, 0);
        check_eq({p, "_stat_err"}, stat_err, 0);
    endtask

    // Monitors, depth FIFO model and N=1 data counter, all on the inactive edge.
    always @(negedge clk) begin
        if (bram_en) begin
            wr_log.push_back({bram_bank, bram_addr, bram_dout});
            $display("WR bank=%0d addr=%0d data=0x%08h", bram_bank, bram_addr, bram_dout);
            check_eq("we_all_ones", bram_we, 4'hF);
        end
        if (canstart && !canstart_prev)
            check_eq("canstart_rise_no_write", bram_en, 0);
        canstart_prev = canstart;
        if (pop_pending && dq.size() > 0) void'(dq.pop_front());
        if (depth_read) pops++;
        pop_pending = depth_read;
        depth_empty = (dq.size() == 0);
        depth       = (dq.size() > 0) ? dq[0] : 32'd0;
        if (b_en) begin
            b_wr_count++;
            b_last_addr = b_addr;
            b_last_data = b_dout;
        end
        if (b_depth_read) b_empty = 1'b1;
        if (b_hs_pending) b_tdata = b_tdata + 32'd1;
        b_hs_pending = b_tvalid && b_tready;
    end

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        tdata = d; tlast = l; tvalid = 1'b1;
        while (!tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("beat_accept", tready, 1);
        @(posedge clk);
        @(negedge clk);
        $display("BEAT data=0x%016h last=%0d", d, l);
        tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0; acc_done = 1'b0; b_tvalid = 1'b0;
        dq.delete();
        pop_pending = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        wr_log.delete();
        pops = 0;
    endtask

    initial begin
        tvalid = 1'b0; tlast = 1'b0; tdata = '0; acc_done = 1'b0;
        depth = '0; depth_empty = 1'b1;
        b_tvalid = 1'b0; b_tdata = '0; b_empty = 1'b1;
        #2;
        do_reset();

        // Case 1: two beats, depth 4
        dq.push_back(32'd4);
        send_beat(64'h0000000200000001, 1'b0);
        send_beat(64'h0000000400000003, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("c1_nwr", wr_log.size(), 4);
        check_wr("c1_w0", 0, 1'b0, 10'd0, 32'd1);
        check_wr("c1_w1", 1, 1'b0, 10'd1, 32'd2);
        check_wr("c1_w2", 2, 1'b0, 10'd2, 32'd3);
        check_wr("c1_w3", 3, 1'b0, 10'd3, 32'd4);
        check_eq("c1_stat_words", stat_words, 4);
        check_eq("c1_canstart", canstart, 1);
        check_eq("c1_acc_bank", acc_bank, 0);
        check_eq("c1_err", stat_err, 0);

        // Case 2: three frames, no done until both banks are full
        do_reset();
        dq.push_back(32'd2); dq.push_back(32'd2); dq.push_back(32'd2);
        send_beat(64'h0000001200000011, 1'b1);
        send_beat(64'h0000002200000021, 1'b1);
        begin
            logic seen;
            seen = 1'b0;
            tdata = 64'h0000003200000031; tlast = 1'b1; tvalid = 1'b1;
            repeat (12) begin
                @(negedge clk);
                if (tready) seen = 1'b1;
            end
            check_eq("c2_tready_held_low", seen, 0);
        end
        check_eq("c2_pops_blocked", pops, 2);
        check_eq("c2_nwr", wr_log.size(), 4);
        check_wr("c2_w0", 0, 1'b0, 10'd0, 32'h11);
        check_wr("c2_w1", 1, 1'b0, 10'd1, 32'h12);
        check_wr("c2_w2", 2, 1'b1, 10'd0, 32'h21);
        check_wr("c2_w3", 3, 1'b1, 10'd1, 32'h22);
        check_eq("c2_canstart", canstart, 1);
        check_eq("c2_acc_bank0", acc_bank, 0);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        send_beat(64'h0000003200000031, 1'b1);
        repeat (4) @(negedge clk);
        check_wr("c2_w4", 4, 1'b0, 10'd0, 32'h31);
        check_wr("c2_w5", 5, 1'b0, 10'd1, 32'h32);
        check_eq("c2_acc_bank1", acc_bank, 1);
        check_eq("c2_canstart_b1", canstart, 1);
        check_eq("c2_pops", pops, 3);

        // Case 3: depth 8, TLAST on beat 2
        do_reset();
        dq.push_back(32'd8);
        send_beat(64'h0000000200000001, 1'b0);
        send_beat(64'h0000000400000003, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("c3_nwr", wr_log.size(), 4);
        check_wr("c3_w3", 3, 1'b0, 10'd3, 32'd4);
        check_eq("c3_err", stat_err, 0);
`ifdef AXIS2BRAM_TLAST_CHECK_EN
        check_eq("c3_stat_words", stat_words, 4);
        check_eq("c3_canstart", canstart, 1);
`else
        check_eq("c3_stat_words", stat_words, 0);
        check_eq("c3_canstart", canstart, 0);
        check_eq("c3_still_recv", tready, 1);
`endif

        // Case 4: depth 2, three beats
        do_reset();
        dq.push_back(32'd2);
`ifdef AXIS2BRAM_TLAST_CHECK_EN
        send_beat(64'h0000000200000001, 1'b0);
        send_beat(64'h0000000400000003, 1'b0);
        send_beat(64'h0000000600000005, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("c4_nwr", wr_log.size(), 2);
        check_wr("c4_w1", 1, 1'b0, 10'd1, 32'd2);
        check_eq("c4_err", stat_err, 1);
        check_eq("c4_stat_words", stat_words, 2);
        check_eq("c4_idle", tready, 0);
`else
        dq.push_back(32'd2);
        send_beat(64'h0000000200000001, 1'b0);
        send_beat(64'h0000000400000003, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("c4_nwr", wr_log.size(), 4);
        check_wr("c4_w1", 1, 1'b0, 10'd1, 32'd2);
        check_wr("c4_w2", 2, 1'b1, 10'd0, 32'd3);
        check_wr("c4_w3", 3, 1'b1, 10'd1, 32'd4);
        check_eq("c4_err", stat_err, 0);
`endif

        // Case 5: N=1, depth 0 clamps to a full bank
        do_reset();
        b_wr_count = 0; b_tdata = '0; b_hs_pending = 1'b0;
        b_empty = 1'b0; b_tvalid = 1'b1;
        begin
            int n;
            n = 0;
            while (!b_canstart && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) @(negedge clk);
        b_tvalid = 1'b0;
        check_eq("c5_canstart", b_canstart, 1);
        check_eq("c5_nwr", b_wr_count, 1024);
        check_eq("c5_last_addr", b_last_addr, 1023);
        check_eq("c5_last_data", b_last_data, 1023);
        check_eq("c5_stat_words", b_stat_words, 1024);
        check_eq("c5_bank", b_bank, 0);

        // Case 6: reset after 3 of 8 words
        do_reset();
        dq.push_back(32'd8);
        send_beat(64'h0000002200000021, 1'b0);
        send_beat(64'h0000002400000023, 1'b0);
        #2 rst_n = 1'b0;
        dq.delete();
        pop_pending = 1'b0;
        #1;
        check_zero_outputs("c6");
        repeat (3) @(negedge clk);
        check_eq("c6_nwr", wr_log.size(), 3);
        check_wr("c6_w2", 2, 1'b0, 10'd2, 32'h23);
        rst_n = 1'b1;
        @(negedge clk);
        wr_log.delete();
        dq.push_back(32'd2);
        send_beat(64'h0000000B0000000A, 1'b1);
        repeat (4) @(negedge clk);
        check_wr("c6_after_w0", 0, 1'b0, 10'd0, 32'hA);
        check_wr("c6_after_w1", 1, 1'b0, 10'd1, 32'hB);
        check_eq("c6_canstart", canstart, 1);
        check_eq("c6_acc_bank", acc_bank, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis2bram_writer.md
# axis2bram_writer

Input-side stream adapter and the write-direction counterpart of the accelerator output path. Accepts an AXI4-Stream slave frame, splits each beat into BRAM-width words and writes them into one of two ping-pong BRAM banks. Frame length comes from a first-word-fall-through depth FIFO. A bank is handed to the accelerator only when complete, and is recycled on accelerator done.

## Interface
- C_AXIS_DATA_WIDTH, 64, stream width. Must equal N × C_BRAM_DATA_WIDTH, with N in {1, 2, 4}.
- C_BRAM_DATA_WIDTH, 32, BRAM word width. Multiple of 8.
- C_BRAM_ADDR_WIDTH, 10, per-bank word address width.
- C_BRAM_DATA_DEPTH, 1024, words per bank. ≤ 2^C_BRAM_ADDR_WIDTH.
- ACC_CLK  in  1  sole clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AXIS_TDATA  in  C_AXIS_DATA_WIDTH  stream data; lane 0 = bits [C_BRAM_DATA_WIDTH-1:0].
- AXIS_TVALID  in  1  beat valid.
- AXIS_TLAST  in  1  last beat of frame.
- AXIS_TREADY  out  1  beat accept.
- DATA_DEPTH  in  32  frame length in BRAM words (FWFT head).
- DATA_DEPTH_EMPTY  in  1  depth FIFO empty.
- DATA_DEPTH_READ  out  1  one-cycle pop of the depth FIFO.
- BRAM_ADDR  out  C_BRAM_ADDR_WIDTH  write word address.
- BRAM_DOUT  out  C_BRAM_DATA_WIDTH  write data.
- BRAM_WE  out  C_BRAM_DATA_WIDTH/8  byte enables; all ones or all zeros.
- BRAM_EN  out  1  port enable.
- BRAM_BANK  out  1  bank targeted by the current write.
- CTRL_CANSTART  out  1  bank CTRL_ACC_BANK is full.
- CTRL_ACC_BANK  out  1  bank the accelerator owns.
- CTRL_ACC_DONE  in  1  one-cycle pulse: accelerator has finished with CTRL_ACC_BANK.
- STAT_WORDS  out  C_BRAM_ADDR_WIDTH+1  word count of the last completed frame.
- STAT_TLAST_ERR  out  1  sticky: a frame exceeded its depth before TLAST.

## Operation
- Bank state: full[1:0], wr_bank, acc_bank. Filling is permitted only while full[wr_bank]=0.
- FSM states: IDLE, LOAD, RECV, SPLIT, DRAIN.
- IDLE → LOAD when DATA_DEPTH_EMPTY=0 and full[wr_bank]=0.
- LOAD:
  - DATA_DEPTH_READ=1 for exactly this cycle; DATA_DEPTH is latched.
  - Depth 0 or depth > C_BRAM_DATA_DEPTH is clamped to C_BRAM_DATA_DEPTH.
  - Word address clears to 0. Next state is RECV.
- RECV:
  - AXIS_TREADY=1.
  - On handshake, lane 0 is written.
  - If N>1, go to SPLIT for lanes 1..N-1, one per cycle, in ascending order.
- Frame end occurs when the word count reaches depth, or when a TLAST beat's lanes are written.
  - On a TLAST beat, lanes beyond depth are not written.
  - On frame end: full[wr_bank] is set, wr_bank toggles, STAT_WORDS is loaded, and the FSM returns to IDLE.
- Depth reached with TLAST not yet seen:
  - STAT_TLAST_ERR is set and the bank is completed normally.
  - FSM enters DRAIN: TREADY=1, beats are discarded, no writes, until the TLAST handshake, then IDLE.
- Accelerator side:
  - CTRL_CANSTART = full[acc_bank].
  - CTRL_ACC_DONE while full[acc_bank]=1 clears full[acc_bank] and toggles acc_bank.
  - CTRL_ACC_DONE while the bank is not full is ignored.
- Simultaneous frame end and CTRL_ACC_DONE always target different banks; both take effect.

## Timing
- Reset values: TREADY, DATA_DEPTH_READ, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DOUT, BRAM_BANK, CTRL_CANSTART, CTRL_ACC_BANK, STAT_WORDS and STAT_TLAST_ERR are all 0. full=00, FSM in IDLE.
- BRAM signals are registered.
  - A beat accepted at edge t presents lane k with BRAM_EN=1 and WE all ones during cycle t+1+k.
  - EN and WE are 0 in all other cycles.
- AXIS_TREADY is decoded from registered state only; it has no combinational path from TVALID.
- Throughput: one beat per N cycles, plus 2 cycles of IDLE/LOAD overhead per frame.
- CTRL_CANSTART rises no earlier than the cycle after the last write cycle of the frame.
- Reset asserted mid-frame discards the partial frame and clears both banks; no further writes occur.

## Configuration
- AXIS2BRAM_TLAST_CHECK_EN defined: TLAST ends frames early, and the DRAIN state and STAT_TLAST_ERR are active as described above.
- Not defined: TLAST is ignored, frames end only on depth, DRAIN does not exist, and STAT_TLAST_ERR is tied to 0.

## Test plan
- Case 1: N=2, depth 4, two beats 0x0000000200000001 and 0x0000000400000003 (TLAST on beat 2). Required: writes 1, 2, 3, 4 to addresses 0–3 of bank 0; STAT_WORDS=4; CTRL_CANSTART=1 with CTRL_ACC_BANK=0.
- Case 2: three frames back-to-back with no CTRL_ACC_DONE. Required: banks 0 and 1 fill; TREADY stays 0 and DATA_DEPTH_READ is not issued for frame 3. After one CTRL_ACC_DONE pulse, frame 3 writes bank 0 and CTRL_ACC_BANK=1.
- Case 3: depth 8 with TLAST on beat 2 (N=2), macro defined. Required: 4 words written; STAT_WORDS=4; STAT_TLAST_ERR=0.
- Case 4: depth 2 with 3 beats (N=2), TLAST on beat 3, macro defined. Required: 2 words written; STAT_TLAST_ERR=1; beats 2–3 accepted without writes. With the macro undefined, beats 2–3 start the next frame.
- Case 5: depth 0 at N=1. Required: frame length C_BRAM_DATA_DEPTH (1024) and final address 1023.
- Case 6: ARESETN low after 3 of 8 words. Required: all outputs 0 and full=00. After release, the next frame starts at bank 0, address 0.
